// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller: state
// encoding, lamp patterns and default phase durations.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G1 = 3'd0,
    MAIN_G2 = 3'd1,
    MAIN_Y  = 3'd2,
    WALK    = 3'd3,
    SIDE_G1 = 3'd4,
    SIDE_G2 = 3'd5,
    SIDE_Y  = 3'd6
  } state_t;

  // Lamp patterns, {R,Y,G}
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // Default phase durations in ticks, and the timer width that holds them
  localparam int DEF_T_BASE = 6;
  localparam int DEF_T_EXT  = 3;
  localparam int DEF_T_YEL  = 2;
  localparam int DEF_TW     = 4;

  // Number of ticks a given state lasts
  function automatic int phase_ticks(state_t s, int t_base, int t_ext, int t_yel);
    int ticks;
    case (s)
      MAIN_G2, SIDE_G2, WALK: ticks = t_ext;
      MAIN_Y, SIDE_Y:         ticks = t_yel;
      default:                ticks = t_base;
    endcase
    return ticks;
  endfunction

endpackage

// File: rtl/traffic_light_fsm_interval_timer.sv
// Loadable down-counter measuring phase length in ticks. expire flags the
// tick on which the current phase ends; the owner reloads on that cycle.
module interval_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic          expire
);

  logic [TW-1:0] count_q, count_d;

  assign expire = tick && (count_q == TW'(1));

  // Load wins; otherwise count down on ticks, never below 1
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q > TW'(1))) begin
      count_d = count_q - TW'(1);
    end
  end

  // Count register; reset takes the value the owner presents for the reset state
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= load_val;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main sequencing FSM of the traffic light controller. Cycles main green,
// yellow, optional walk, side green, yellow, stretching greens when a
// vehicle is sensed and serving a latched walk request once per round.
//
// Handshake with the walk register: WR is a level request held by the walk
// register; it is sampled only at the end of MAIN_Y. When the walk phase
// has been served the FSM answers with WR_Reset, high for exactly the one
// cycle after leaving WALK; the walk register clears on that pulse. Reset
// never produces the pulse, so a pending request survives reset.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int T_BASE = DEF_T_BASE,
  parameter int T_EXT  = DEF_T_EXT,
  parameter int T_YEL  = DEF_T_YEL,
  parameter int TW     = DEF_TW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       sensor,
  input  logic       WR,
  output logic       WR_Reset,
  output logic [2:0] main_lt,
  output logic [2:0] side_lt,
  output logic       walk_lt,
  output logic [2:0] state_dbg_o
);

  localparam int T_MAX = (1 << TW) - 1;

  // Durations of zero or wider than the timer are configuration errors
  if (T_BASE < 1 || T_BASE > T_MAX || T_EXT < 1 || T_EXT > T_MAX ||
      T_YEL < 1 || T_YEL > T_MAX) begin : g_bad_durations
    $error("traffic_light_fsm: phase durations must lie in 1..2**TW-1");
  end

  state_t        state_q, state_d;
  logic          expire;
  logic          illegal;
  logic          load;
  logic [TW-1:0] load_val;
  logic          wr_reset_q, wr_reset_d;

  // Reload the timer whenever the state is (re)entered
  assign load     = reset | expire | illegal;
  assign load_val = TW'(phase_ticks(state_d, T_BASE, T_EXT, T_YEL));

  interval_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .expire   (expire)
  );

  // State and walk-served pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MAIN_G1;
      wr_reset_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_reset_q <= wr_reset_d;
    end
  end

  // Next state: decisions are taken only on the tick that ends a phase
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      MAIN_G1: if (expire) state_d = sensor ? MAIN_G2 : MAIN_Y;
      MAIN_G2: if (expire) state_d = MAIN_Y;
      MAIN_Y:  if (expire) state_d = WR ? WALK : SIDE_G1;
      WALK:    if (expire) state_d = SIDE_G1;
      SIDE_G1: if (expire) state_d = sensor ? SIDE_G2 : SIDE_Y;
      SIDE_G2: if (expire) state_d = SIDE_Y;
      SIDE_Y:  if (expire) state_d = MAIN_G1;
      default: begin
        state_d = MAIN_G1;
        illegal = 1'b1;
      end
    endcase
    if (reset) begin
      state_d = MAIN_G1;
    end
  end

  // Pulse is raised by the WALK exit edge and lasts one cycle
  assign wr_reset_d = (state_q == WALK) && expire;

  // Lamp decode straight from the state register
  always_comb begin
    main_lt = LT_RED;
    side_lt = LT_RED;
    walk_lt = 1'b0;
    case (state_q)
      MAIN_G1, MAIN_G2: main_lt = LT_GRN;
      MAIN_Y:           main_lt = LT_YEL;
      WALK:             walk_lt = 1'b1;
      SIDE_G1, SIDE_G2: side_lt = LT_GRN;
      SIDE_Y:           side_lt = LT_YEL;
      default: begin
        main_lt = LT_RED;
        side_lt = LT_RED;
      end
    endcase
  end

  assign WR_Reset    = wr_reset_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: directed scenarios followed by random
// traffic, every cycle compared against a phase-table reference model.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       sensor = 1'b0;
  logic       WR = 1'b0;
  logic       WR_Reset;
  logic [2:0] main_lt, side_lt, state_dbg;
  logic       walk_lt;

  traffic_light_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .sensor      (sensor),
    .WR          (WR),
    .WR_Reset    (WR_Reset),
    .main_lt     (main_lt),
    .side_lt     (side_lt),
    .walk_lt     (walk_lt),
    .state_dbg_o (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: which phase of the round we are in and how many
  // ticks of it have elapsed.
  typedef enum {P_MG1, P_MG2, P_MY, P_WALK, P_SG1, P_SG2, P_SY} ph_e;
  ph_e  m_ph = P_MG1;
  int   m_el = 0;
  logic m_wrr = 1'b0;

  int tick_mode = 0;  // 0: every cycle, N>0: every N cycles, -1: random
  int div_cnt = 0;
  logic last_wrr;

  function automatic int ph_len(ph_e p);
    case (p)
      P_MG1, P_SG1:         return 6;
      P_MG2, P_SG2, P_WALK: return 3;
      default:              return 2;
    endcase
  endfunction

  // {main, side, walk}
  function automatic logic [6:0] ph_lamps(ph_e p);
    case (p)
      P_MG1, P_MG2: return {3'b001, 3'b100, 1'b0};
      P_MY:         return {3'b010, 3'b100, 1'b0};
      P_WALK:       return {3'b100, 3'b100, 1'b1};
      P_SG1, P_SG2: return {3'b100, 3'b001, 1'b0};
      default:      return {3'b100, 3'b010, 1'b0};
    endcase
  endfunction

  task automatic model_update();
    if (reset) begin
      m_ph = P_MG1;
      m_el = 0;
      m_wrr = 1'b0;
    end else begin
      m_wrr = 1'b0;
      if (tick) begin
        m_el++;
        if (m_el == ph_len(m_ph)) begin
          m_el = 0;
          case (m_ph)
            P_MG1:  m_ph = sensor ? P_MG2 : P_MY;
            P_MG2:  m_ph = P_MY;
            P_MY:   m_ph = WR ? P_WALK : P_SG1;
            P_WALK: begin m_ph = P_SG1; m_wrr = 1'b1; end
            P_SG1:  m_ph = sensor ? P_SG2 : P_SY;
            P_SG2:  m_ph = P_SY;
            default: m_ph = P_MG1;
          endcase
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one clock of stimulus, then model step and checks
  task automatic step(input logic press);
    logic [6:0] exp_l;
    logic       safe;
    @(negedge clk);
    if (m_wrr) WR = 1'b0;
    else if (press) WR = 1'b1;
    if (tick_mode == 0) tick = 1'b1;
    else if (tick_mode < 0) tick = ($urandom_range(0, 2) == 0);
    else begin
      tick = (div_cnt == 0);
      div_cnt = (div_cnt + 1) % tick_mode;
    end
    @(posedge clk);
    model_update();
    #1;
    exp_l = ph_lamps(m_ph);
    chk("main_lt", main_lt, exp_l[6:4]);
    chk("side_lt", side_lt, exp_l[3:1]);
    chk("walk_lt", walk_lt, exp_l[0]);
    chk("WR_Reset", WR_Reset, m_wrr);
    safe = !(main_lt != 3'b100 && side_lt != 3'b100) &&
           (!walk_lt || (main_lt == 3'b100 && side_lt == 3'b100)) &&
           $onehot(main_lt) && $onehot(side_lt);
    chk("safety", safe, 1'b1);
  endtask

  function automatic logic lamp_on(int sel);
    case (sel)
      0:       return main_lt == 3'b001;
      1:       return side_lt == 3'b001;
      default: return walk_lt;
    endcase
  endfunction

  // Length in cycles of the next complete run of the selected lamp
  task automatic measure(input int sel, output int n);
    int guard = 0;
    while (lamp_on(sel) && guard < 2000) begin step(1'b0); guard++; end
    while (!lamp_on(sel) && guard < 2000) begin step(1'b0); guard++; end
    n = 0;
    while (lamp_on(sel) && guard < 2000) begin n++; step(1'b0); guard++; end
    last_wrr = WR_Reset;
    if (guard >= 2000) n = -1;
  endtask

  task automatic wait_for(input int sel, input string tag);
    int guard = 0;
    while (!lamp_on(sel) && guard < 2000) begin step(1'b0); guard++; end
    chk(tag, lamp_on(sel), 1'b1);
  endtask

  initial begin
    int n;

    // 1: reset, then the plain 16-tick round
    reset = 1'b1;
    tick_mode = 0;
    step(1'b0);
    step(1'b0);
    chk("reset_main", main_lt, 3'b001);
    chk("reset_side", side_lt, 3'b100);
    chk("reset_walk", walk_lt, 1'b0);
    chk("reset_wrr", WR_Reset, 1'b0);
    reset = 1'b0;
    measure(0, n);
    chk("base_main_green", n, 6);
    measure(1, n);
    chk("base_side_green", n, 6);

    // 2: vehicle always present, greens extended
    sensor = 1'b1;
    measure(0, n);
    chk("ext_main_green", n, 9);
    measure(1, n);
    chk("ext_side_green", n, 9);

    // 3: walk request raised during MAIN_G1
    sensor = 1'b0;
    wait_for(0, "wait_main_green");
    step(1'b1);
    measure(2, n);
    chk("walk_len", n, 3);
    chk("wrr_after_walk", last_wrr, 1'b1);
    step(1'b0);
    chk("wrr_width", WR_Reset, 1'b0);

    // 4: slow tick, phases stretch in clocks
    tick_mode = 5;
    div_cnt = 0;
    measure(0, n);
    chk("slow_main_green", n, 30);

    // 5: reset during the second walk tick
    tick_mode = 0;
    wait_for(0, "wait_main_green2");
    step(1'b1);
    wait_for(2, "wait_walk");
    step(1'b0);
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    chk("rst_walk_main", main_lt, 3'b001);
    chk("rst_walk_walk", walk_lt, 1'b0);
    chk("rst_walk_wrr", WR_Reset, 1'b0);
    chk("rst_keeps_wr", WR, 1'b1);
    measure(2, n);
    chk("walk_after_rst", n, 3);

    // 6: random traffic
    tick_mode = -1;
    for (int i = 0; i < 10000; i++) begin
      sensor = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 499) == 0);
      step($urandom_range(0, 39) == 0);
    end
    reset = 1'b0;
    step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
